uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter that sits directly downstream of the baud tick generator and consumes its single-cycle baud_tick pulse as the bit-period strobe.
- Accepts parallel bytes through a valid/ready handshake into a small internal FIFO.
- Serialises each byte as start, data (LSB first), optional parity and stop bits onto the tx line.
- Back-to-back frames are sent with no idle gap while the FIFO holds data.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- baud_tick  input  1  one-clk pulse per bit period, from the baud generator.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; equals not-full.
- tx  output  1  serial line, idle high.
- busy  output  1  high when state is not IDLE or the FIFO is non-empty.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n low): tx=1, state=IDLE, FIFO empty, fifo_count=0, tx_ready=1, busy=0. The bit counter and shift register clear.
- Reset asserted mid-frame aborts the frame immediately. tx returns high asynchronously and queued bytes are discarded.
- Push: a byte is written when tx_valid && tx_ready are both high on a clk edge. fifo_count increments the next cycle.
- tx_ready is registered-equivalent and is low exactly when fifo_count == FIFO_DEPTH.
- With tx_valid high while full, nothing is written and the data is not lost silently. The producer must hold the data until tx_ready is high.
- Pop: occurs only on a baud_tick in IDLE, or on the final STOP tick, when fifo_count != 0. The popped byte loads the shift register.
- Simultaneous push and pop in the same cycle leaves fifo_count unchanged.
- A push into an empty FIFO is not poppable in that same cycle.
- FIFO read and write pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP. tx is a registered output, updated on the clk edge where baud_tick is high.
  - IDLE: tx=1. On baud_tick with the FIFO non-empty: pop, go to START, tx<=0.
  - START: on baud_tick, go to DATA, tx<=bit0, bit counter=0.
  - DATA: on each baud_tick, shift right and drive the next bit. After bit DATA_BITS-1 has been held for one period:
    - if PARITY!=0, go to PARITY with tx<=parity bit;
    - otherwise go to STOP with tx<=1.
  - Parity bit: even = XOR of the data bits; odd = its inverse.
  - PARITY: on baud_tick, go to STOP, tx<=1.
  - STOP: held for STOP_BITS periods. On the last STOP tick:
    - FIFO non-empty: pop, go to START, tx<=0 (no idle gap);
    - otherwise go to IDLE, tx stays 1.
- Every bit is held for exactly one baud_tick-to-baud_tick interval.
- Start latency is up to one bit period, because a push waits for the next baud_tick.
- baud_tick is ignored for state advance between ticks. Inputs are sampled on every clk.
- Frame length in periods: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.

Test Plan (bench: 12 MHz clk, baud_tick every 16 clk):
- Reset behaviour: hold rst_n low for 5 clk with tx_valid=1 -> tx=1, tx_ready=1, busy=0, fifo_count=0. No write occurs during reset.
- Single byte, 8N1: push 0xA5 -> after the next baud_tick, tx carries 0,1,0,1,0,0,1,0,1,1 at 16 clk per bit. Then IDLE, busy=0.
- Parity and two stop bits: PARITY=2, STOP_BITS=2, byte 0x07 -> bits 0,1,1,1,0,0,0,0,0,1,1,1. Parity bit =1.
- Odd parity: PARITY=1, byte 0x00 -> parity bit =1.
- FIFO full and back-to-back: push 5 bytes 0x11..0x15 on consecutive clk before any tick:
  - tx_ready drops after the 4th accepted push (fifo_count=4); the 5th byte is held.
  - After the first pop, fifo_count=3 and tx_ready=1, so the 5th byte is accepted.
  - The stop bit of frame N is immediately followed by the start bit of frame N+1, with no extra high period.
- Mid-frame reset: pull rst_n low during DATA bit 3 of 0x00 with 2 bytes queued -> tx=1 within the same cycle (async). fifo_count=0 after release, and no residual frame is sent.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: a small byte FIFO feeds a start/data/parity/stop serialiser.
// The serialiser advances only on baud_tick, and each bit lasts one tick interval.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          baud_tick,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_reg;
   logic [AW-1:0]        rd_ptr_reg;
   logic [AW:0]          count_reg;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head_data;

   state_t               state_reg, state_next;
   logic                 tx_reg, tx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
   logic                 stop_cnt_reg, stop_cnt_next;
   logic                 parity_reg, parity_next;
   logic                 load_frame;

   assign tx_ready   = (count_reg != (AW+1)'(FIFO_DEPTH));
   assign push       = tx_valid && tx_ready;
   assign head_data  = fifo_mem[rd_ptr_reg];
   assign fifo_count = count_reg;
   assign tx         = tx_reg;
   assign busy       = (state_reg != S_IDLE) || (count_reg != '0);

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         tx_reg       <= 1'b1;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         parity_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tx_reg       <= tx_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         parity_reg   <= parity_next;
      end
   end

   // Pop decisions use the registered count, so a byte pushed this cycle waits.
   always_comb begin
      state_next    = state_reg;
      tx_next       = tx_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      parity_next   = parity_reg;
      load_frame    = 1'b0;
      pop           = 1'b0;

      if (baud_tick) begin
         case (state_reg)
            S_IDLE: begin
               if (count_reg != '0) begin
                  load_frame = 1'b1;
               end
            end
            S_START: begin
               state_next   = S_DATA;
               tx_next      = shift_reg[0];
               bit_cnt_next = '0;
            end
            S_DATA: begin
               if (bit_cnt_reg == BW'(DATA_BITS-1)) begin
                  stop_cnt_next = 1'b0;
                  if (PARITY != 0) begin
                     state_next = S_PARITY;
                     tx_next    = parity_reg;
                  end else begin
                     state_next = S_STOP;
                     tx_next    = 1'b1;
                  end
               end else begin
                  shift_next   = shift_reg >> 1;
                  tx_next      = shift_reg[1];
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
            S_PARITY: begin
               state_next    = S_STOP;
               tx_next       = 1'b1;
               stop_cnt_next = 1'b0;
            end
            S_STOP: begin
               if (stop_cnt_reg == 1'(STOP_BITS-1)) begin
                  if (count_reg != '0) begin
                     load_frame = 1'b1;
                  end else begin
                     state_next = S_IDLE;
                     tx_next    = 1'b1;
                  end
               end else begin
                  stop_cnt_next = stop_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = S_IDLE;
               tx_next    = 1'b1;
            end
         endcase
      end

      // Shared by IDLE and the last stop bit: the new frame starts immediately.
      if (load_frame) begin
         pop         = 1'b1;
         state_next  = S_START;
         tx_next     = 1'b0;
         shift_next  = head_data;
         parity_next = (PARITY == 1) ? ~(^head_data) : (^head_data);
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) checked every clock
// against a per-bit-period frame model with queue-level FIFO tracking.
module tb_uart_tx;

   localparam int N     = 3;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          baud_tick = 1'b0;
   logic [7:0]    d [N];
   logic [N-1:0]  v;
   logic [N-1:0]  rdy;
   logic [N-1:0]  txw;
   logic [N-1:0]  busyw;
   logic [2:0]    fc [N];

   // Reference model state
   logic [7:0]    mq [N][DEPTH];
   int            mhead [N];
   int            mcnt [N];
   logic [15:0]   fbits [N];
   int            fidx [N];
   int            frem [N];

   // Producer queues and line capture
   logic [7:0]    sbuf [N][256];
   int            shead [N];
   int            stail [N];
   logic          force_v;
   int            tick_div;
   logic [63:0]   cap [N];
   int            cap_n [N];
   logic          cap_on [N];

   int            n_checks;
   int            n_errors;

   uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
      .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
      .tx(txw[0]), .busy(busyw[0]), .fifo_count(fc[0])
   );

   uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_8e2 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
      .tx_data(d[1]), .tx_valid(v[1]), .tx_ready(rdy[1]),
      .tx(txw[1]), .busy(busyw[1]), .fifo_count(fc[1])
   );

   uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
      .tx_data(d[2]), .tx_valid(v[2]), .tx_ready(rdy[2]),
      .tx(txw[2]), .busy(busyw[2]), .fifo_count(fc[2])
   );

   // Nominal 12 MHz clock; baud_tick is asserted every 16th cycle.
   always #42 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int par_of(input int k);
      return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
   endfunction

   function automatic int flen(input int k);
      return 1 + 8 + ((par_of(k) != 0) ? 1 : 0) + ((k == 1) ? 2 : 1);
   endfunction

   // Bit i of the result is the line level during period i of the frame.
   function automatic logic [15:0] frame_of(input logic [7:0] b, input int par);
      logic [15:0] f;
      logic        p;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      if (par != 0) begin
         p = ^b;
         if (par == 1) p = ~p;
         f[9] = p;
      end
      return f;
   endfunction

   function automatic logic all_idle();
      logic r;
      r = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (frem[k] != 0 || mcnt[k] != 0 || shead[k] != stail[k]) r = 1'b0;
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mhead[k] = 0;
         mcnt[k]  = 0;
         frem[k]  = 0;
         fidx[k]  = 0;
      end
   endtask

   task automatic clear_cap();
      for (int k = 0; k < N; k++) begin
         cap[k]    = '0;
         cap_n[k]  = 0;
         cap_on[k] = 1'b0;
      end
   endtask

   task automatic enqueue(input int k, input logic [7:0] b);
      sbuf[k][stail[k]] = b;
      stail[k] = (stail[k] + 1) % 256;
   endtask

   task automatic step();
      logic acc;
      logic exp_tx;
      baud_tick = (tick_div == 15);
      for (int k = 0; k < N; k++) begin
         v[k] = force_v || (shead[k] != stail[k]);
         d[k] = (shead[k] != stail[k]) ? sbuf[k][shead[k]] : 8'hFF;
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         acc = v[k] && rst_n && (mcnt[k] < DEPTH);
         if (!rst_n) begin
            mhead[k] = 0;
            mcnt[k]  = 0;
            frem[k]  = 0;
            fidx[k]  = 0;
         end else begin
            if (baud_tick) begin
               if (frem[k] > 0) begin
                  frem[k]--;
                  fidx[k]++;
               end
               if (frem[k] == 0 && mcnt[k] > 0) begin
                  fbits[k] = frame_of(mq[k][mhead[k]], par_of(k));
                  mhead[k] = (mhead[k] + 1) % DEPTH;
                  mcnt[k]--;
                  fidx[k]  = 0;
                  frem[k]  = flen(k);
               end
            end
            if (acc) begin
               mq[k][(mhead[k] + mcnt[k]) % DEPTH] = d[k];
               mcnt[k]++;
               $display("push inst=%0d data=%02h count=%0d", k, d[k], mcnt[k]);
               if (shead[k] != stail[k]) shead[k] = (shead[k] + 1) % 256;
            end
         end
      end
      tick_div = (tick_div + 1) % 16;
      #1;
      for (int k = 0; k < N; k++) begin
         exp_tx = (frem[k] > 0) ? fbits[k][fidx[k]] : 1'b1;
         check($sformatf("tx[%0d]", k), 64'(txw[k]), 64'(exp_tx));
         check($sformatf("tx_ready[%0d]", k), 64'(rdy[k]), 64'(mcnt[k] < DEPTH));
         check($sformatf("busy[%0d]", k), 64'(busyw[k]), 64'(frem[k] > 0 || mcnt[k] > 0));
         check($sformatf("fifo_count[%0d]", k), 64'(fc[k]), 64'(mcnt[k]));
         if (baud_tick && rst_n && cap_n[k] < 64) begin
            if (cap_on[k] || !txw[k]) begin
               cap_on[k]        = 1'b1;
               cap[k][cap_n[k]] = txw[k];
               cap_n[k]++;
            end
         end
      end
   endtask

   task automatic run_until_idle(input int maxc);
      int c;
      c = 0;
      while (!all_idle() && c < maxc) begin
         step();
         c++;
      end
      check("drain_timeout", 64'(all_idle()), 64'd1);
      repeat (2) step();
   endtask

   initial begin
      logic [63:0] exp64;
      int          c;
      n_checks = 0;
      n_errors = 0;
      tick_div = 0;
      force_v  = 1'b1;
      for (int k = 0; k < N; k++) begin
         shead[k] = 0;
         stail[k] = 0;
         d[k]     = 8'hFF;
      end
      v = '1;
      model_reset();
      clear_cap();

      // Reset held with tx_valid asserted: nothing may be written.
      rst_n = 1'b0;
      repeat (5) step();
      check("rst_tx", 64'(txw), 64'h7);
      check("rst_ready", 64'(rdy), 64'h7);
      check("rst_busy", 64'(busyw), 64'h0);
      for (int k = 0; k < N; k++) check($sformatf("rst_count[%0d]", k), 64'(fc[k]), 64'd0);
      force_v = 1'b0;
      rst_n   = 1'b1;
      repeat (3) step();

      // Single frames with known bit patterns.
      clear_cap();
      enqueue(0, 8'hA5);
      enqueue(1, 8'h07);
      enqueue(2, 8'h00);
      run_until_idle(2000);
      check("frame_8n1_a5", 64'(cap[0][9:0]), 64'h34A);
      check("frame_8e2_07", 64'(cap[1][11:0]), 64'hE0E);
      check("frame_8o1_00", 64'(cap[2][10:0]), 64'h600);
      check("idle_busy", 64'(busyw), 64'h0);

      // FIFO full, hold of the fifth byte, then back-to-back frames.
      while (tick_div != 0) step();
      clear_cap();
      for (int i = 0; i < 5; i++) enqueue(0, 8'h11 + 8'(i));
      repeat (4) step();
      check("full_count", 64'(fc[0]), 64'd4);
      check("full_ready", 64'(rdy[0]), 64'd0);
      c = 0;
      while (mcnt[0] != 3 && c < 64) begin
         step();
         c++;
      end
      check("first_pop_count", 64'(fc[0]), 64'd3);
      check("first_pop_ready", 64'(rdy[0]), 64'd1);
      run_until_idle(4000);
      exp64 = '0;
      for (int i = 0; i < 5; i++) begin
         exp64 = exp64 | (64'(frame_of(8'h11 + 8'(i), 0) & 16'h03FF) << (10 * i));
      end
      check("b2b_stream", cap[0] & ((64'd1 << 50) - 64'd1), exp64);

      // Randomised traffic on all three transmitters.
      for (int it = 0; it < 3000; it++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 299) == 0) begin
               repeat ($urandom_range(1, 5)) enqueue(k, 8'($urandom()));
            end
         end
         step();
      end
      run_until_idle(30000);

      // Mid-frame reset during data bit 3 with two bytes still queued.
      enqueue(0, 8'h00);
      enqueue(0, 8'h55);
      enqueue(0, 8'h66);
      c = 0;
      while (!(frem[0] > 0 && fidx[0] == 4) && c < 1000) begin
         step();
         c++;
      end
      check("reach_bit3", 64'(c < 1000), 64'd1);
      repeat (5) step();
      check("pre_rst_tx", 64'(txw[0]), 64'd0);
      check("pre_rst_count", 64'(fc[0]), 64'd2);
      rst_n = 1'b0;
      model_reset();
      for (int k = 0; k < N; k++) shead[k] = stail[k];
      #1;
      check("async_tx", 64'(txw[0]), 64'd1);
      check("async_count", 64'(fc[0]), 64'd0);
      check("async_busy", 64'(busyw[0]), 64'd0);
      repeat (3) step();
      rst_n = 1'b1;
      clear_cap();
      repeat (400) step();
      check("no_residual_frame", 64'(cap_n[0]), 64'd0);
      check("post_rst_count", 64'(fc[0]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
